// File: rtl/step_seq_pkg.sv
// Shared opcodes, sequencer state encoding and step increments for the stepper move sequencer.
package step_seq_pkg;

  localparam logic [1:0] OP_MOVR   = 2'd0;
  localparam logic [1:0] OP_MOVRHS = 2'd1;
  localparam logic [1:0] OP_PAUSE  = 2'd2;
  localparam logic [1:0] OP_NOP    = 2'd3;

  // Positions count half-steps, so a full step moves two units.
  localparam int INC_FULL = 2;
  localparam int INC_HALF = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_DELAY,
    S_PDELAY
  } state_t;

endpackage

// File: rtl/step_delay_timer.sv
// Loadable down-counter pacing steps and pauses; expired is high during the load_val-th enabled cycle.
// No handshake: load wins over enable, and the count holds while enable is low.
module step_delay_timer #(
  parameter int DLY_W = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [DLY_W-1:0] load_val,
  input  logic             enable,
  output logic             expired
);

  logic [DLY_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DLY_W'(1);
    end
  end

  assign expired = enable && (cnt_q == DLY_W'(1));

endmodule

// File: rtl/step_move_sequencer.sv
// Multi-channel stepper sequencer: MOVR/MOVRHS/PAUSE/NOP with paced steps and a done pulse; first step at accept+3.
// One command in flight: cmd_ready is high only in IDLE, and abort ends the current command on the next cycle.
module step_move_sequencer
  import step_seq_pkg::*;
#(
  parameter  int NUM_CH = 2,
  parameter  int POS_W  = 8,
  parameter  int CNT_W  = 8,
  parameter  int DLY_W  = 20,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [CH_W-1:0]         cmd_ch,
  input  logic signed [CNT_W-1:0] cmd_count,
  input  logic [DLY_W-1:0]        cmd_delay,
  input  logic                    abort,
  output logic [NUM_CH*POS_W-1:0] pos_q,
  output logic [NUM_CH-1:0]       step_pulse,
  output logic [NUM_CH-1:0]       dir,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    aborted
);

  localparam logic signed [CNT_W-1:0] ONE = 1;

  state_t                  state_q, state_d;
  logic [1:0]              op_q;
  logic [CH_W-1:0]         ch_q;
  logic signed [CNT_W-1:0] count_q;
  logic signed [CNT_W-1:0] temp_q;
  logic [DLY_W-1:0]        dly_q;
  logic [POS_W-1:0]        pos_r [NUM_CH];

  logic accept, ch_ok, step_neg;
  logic do_step, temp_load, tmr_load, tmr_en, tmr_expired;
  logic done_d, err_d, aborted_d;
  logic [POS_W-1:0] inc;

  assign accept    = (state_q == S_IDLE) && cmd_valid;
  assign ch_ok     = (int'(ch_q) < NUM_CH);
  assign step_neg  = temp_q[CNT_W-1];
  assign inc       = (op_q == OP_MOVR) ? POS_W'(INC_FULL) : POS_W'(INC_HALF);
  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = !cmd_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pos
    assign pos_q[g*POS_W +: POS_W] = pos_r[g];
  end

  step_delay_timer #(
    .DLY_W(DLY_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(dly_q),
    .enable  (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    do_step   = 1'b0;
    temp_load = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (op_q == OP_PAUSE) begin
          tmr_load = 1'b1;
          state_d  = S_PDELAY;
        end else if (op_q == OP_NOP) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (!ch_ok) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          temp_load = 1'b1;
          state_d   = S_STEP;
        end
      end
      S_STEP: begin
        // Abort wins over a pending step so the position is left untouched.
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (temp_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          do_step  = 1'b1;
          tmr_load = 1'b1;
          state_d  = S_DELAY;
        end
      end
      S_DELAY, S_PDELAY: begin
        if (abort) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          tmr_en = 1'b1;
          if (tmr_expired) begin
            state_d = (state_q == S_DELAY) ? S_STEP : S_IDLE;
            done_d  = (state_q == S_PDELAY);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_q       <= OP_NOP;
      ch_q       <= '0;
      count_q    <= '0;
      temp_q     <= '0;
      dly_q      <= DLY_W'(1);
      dir        <= '0;
      step_pulse <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      aborted    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) pos_r[i] <= '0;
    end else begin
      state_q    <= state_d;
      done       <= done_d;
      err        <= err_d;
      aborted    <= aborted_d;
      step_pulse <= '0;
      if (accept) begin
        op_q    <= cmd_op;
        ch_q    <= cmd_ch;
        count_q <= cmd_count;
        dly_q   <= (cmd_delay == '0) ? DLY_W'(1) : cmd_delay;
      end
      if (temp_load) temp_q <= count_q;
      if (do_step) begin
        temp_q <= step_neg ? temp_q + ONE : temp_q - ONE;
        for (int i = 0; i < NUM_CH; i++) begin
          if (CH_W'(i) == ch_q) begin
            pos_r[i]      <= step_neg ? pos_r[i] - inc : pos_r[i] + inc;
            dir[i]        <= step_neg;
            step_pulse[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_step_move_sequencer.sv
// Scoreboard bench for step_move_sequencer with three channels: expected step and done events are
// queued at command issue and compared, cycle-exact, when the DUT pulses.
module tb_step_move_sequencer;
  import step_seq_pkg::*;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [1:0]         cmd_ch = 2'd0;
  logic signed [7:0]  cmd_count = '0;
  logic [19:0]        cmd_delay = '0;
  logic               abort = 1'b0;
  logic [23:0]        pos_q;
  logic [2:0]         step_pulse;
  logic [2:0]         dir;
  logic               busy, done, err, aborted;

  step_move_sequencer #(
    .NUM_CH(3), .POS_W(8), .CNT_W(8), .DLY_W(20)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_ch    (cmd_ch),
    .cmd_count (cmd_count),
    .cmd_delay (cmd_delay),
    .abort     (abort),
    .pos_q     (pos_q),
    .step_pulse(step_pulse),
    .dir       (dir),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .aborted   (aborted)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [2:0] pulse;
    logic [23:0] pos;
    logic [2:0] dir;
  } step_t;

  typedef struct {
    int         cyc;
    logic       err;
    logic       ab;
    logic [23:0] pos;
  } done_t;

  step_t      step_q[$];
  done_t      done_q[$];
  logic [7:0] exp_pos [3];
  logic [2:0] exp_dir;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pack_pos();
    logic [23:0] v;
    for (int i = 0; i < 3; i++) v[i*8 +: 8] = exp_pos[i];
    return v;
  endfunction

  task automatic push_done(input int c, input bit e, input bit a);
    done_t x;
    x.cyc = c; x.err = e; x.ab = a; x.pos = pack_pos();
    done_q.push_back(x);
  endtask

  // Queue the first max_steps steps of a move and, optionally, its normal completion.
  task automatic push_move(input int t, input logic [1:0] op, input int ch, input int count,
                           input int delay, input int max_steps, input bit with_done);
    int n, d, ns;
    logic [7:0] inc;
    step_t s;
    n   = (count < 0) ? -count : count;
    d   = (delay < 1) ? 1 : delay;
    ns  = (n < max_steps) ? n : max_steps;
    inc = (op == OP_MOVR) ? 8'd2 : 8'd1;
    for (int k = 0; k < ns; k++) begin
      if (count < 0) exp_pos[ch] = exp_pos[ch] - inc;
      else           exp_pos[ch] = exp_pos[ch] + inc;
      exp_dir[ch] = (count < 0);
      s.cyc   = t + 3 + k * (d + 1);
      s.pulse = 3'b001 << ch;
      s.pos   = pack_pos();
      s.dir   = exp_dir;
      step_q.push_back(s);
    end
    if (with_done) push_done(t + 3 + n * (d + 1), 1'b0, 1'b0);
  endtask

  // Presents a command from a falling edge and returns the cycle in which it was accepted.
  task automatic send_cmd(input logic [1:0] op, input int ch, input int count, input int delay,
                          output int t);
    int budget;
    budget = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_ch    = ch[1:0];
    cmd_count = count[7:0];
    cmd_delay = delay[19:0];
    while (!cmd_ready && budget < 3000) begin
      @(negedge clk);
      budget++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 64'd0, 64'd1);
      t = -100000;
    end else begin
      t = cyc;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin : mon
    step_t s;
    done_t x;
    if (|step_pulse) begin
      if (step_q.size() == 0) begin
        check("unexpected_step", {61'd0, step_pulse}, 64'd0);
      end else begin
        s = step_q.pop_front();
        check("step_cyc", cyc, s.cyc);
        check("step_pulse", step_pulse, s.pulse);
        check("step_pos", pos_q, s.pos);
        check("step_dir", dir, s.dir);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        x = done_q.pop_front();
        check("done_cyc", cyc, x.cyc);
        check("done_err", err, x.err);
        check("done_aborted", aborted, x.ab);
        check("done_pos", pos_q, x.pos);
      end
    end else if (err || aborted) begin
      check("flag_without_done", {err, aborted}, 2'b00);
    end
  end

  initial begin
    int t, t2;
    for (int i = 0; i < 3; i++) exp_pos[i] = 8'd0;
    exp_dir = 3'b000;

    // Power-on reset with no command pending.
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pos", pos_q, 24'd0);
    check("rst_pulse", step_pulse, 3'b000);
    check("rst_dir", dir, 3'b000);
    check("rst_done", {done, err, aborted}, 3'b000);
    reset_n = 1'b1;

    // Reset during a move: first step lands, then everything is discarded.
    send_cmd(OP_MOVR, 0, 3, 4, t);
    push_move(t, OP_MOVR, 0, 3, 4, 1, 1'b0);
    wait_cyc(t + 5);
    reset_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) exp_pos[i] = 8'd0;
    exp_dir = 3'b000;
    check("midrst_ready", cmd_ready, 1'b1);
    check("midrst_pos", pos_q, 24'd0);
    check("midrst_done", done, 1'b0);
    reset_n = 1'b1;

    // Full-step move on ch0.
    send_cmd(OP_MOVR, 0, 3, 4, t);
    push_move(t, OP_MOVR, 0, 3, 4, 100, 1'b1);

    // Half-step negative move on ch1 with zero delay wraps below zero.
    send_cmd(OP_MOVRHS, 1, -2, 0, t);
    push_move(t, OP_MOVRHS, 1, -2, 0, 100, 1'b1);

    // Pause, then a zero-count move.
    send_cmd(OP_PAUSE, 0, 0, 10, t);
    push_done(t + 12, 1'b0, 1'b0);
    send_cmd(OP_MOVR, 0, 0, 7, t);
    push_move(t, OP_MOVR, 0, 0, 7, 100, 1'b1);

    // Abort in the second cycle of the second delay, then a back-to-back move.
    send_cmd(OP_MOVR, 0, 5, 8, t);
    push_move(t, OP_MOVR, 0, 5, 8, 2, 1'b0);
    push_done(t + 14, 1'b0, 1'b1);
    wait_cyc(t + 13);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    send_cmd(OP_MOVR, 2, 1, 2, t2);
    check("abort_b2b_accept", t2, t + 14);
    push_move(t2, OP_MOVR, 2, 1, 2, 100, 1'b1);

    // Abort while idle must do nothing.
    wait_cyc(t2 + 8);
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    check("idle_abort_ready", cmd_ready, 1'b1);

    // Invalid channel, then a NOP accepted in the done cycle.
    send_cmd(OP_MOVR, 3, 2, 1, t);
    push_done(t + 2, 1'b1, 1'b0);
    send_cmd(OP_NOP, 0, 0, 0, t2);
    check("err_b2b_accept", t2, t + 2);
    push_done(t2 + 2, 1'b0, 1'b0);

    // Most negative count is a legal 128-half-step move.
    send_cmd(OP_MOVRHS, 2, -128, 0, t);
    push_move(t, OP_MOVRHS, 2, -128, 0, 1000, 1'b1);

    for (int i = 0; i < 400 && (step_q.size() + done_q.size()) != 0; i++) @(negedge clk);
    check("steps_outstanding", step_q.size(), 0);
    check("dones_outstanding", done_q.size(), 0);
    check("final_pos", pos_q, pack_pos());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_move_sequencer.md
# step_move_sequencer

Multi-channel stepper move sequencer. It executes relative full-step (MOVR), half-step (MOVRHS) and PAUSE commands on one of `NUM_CH` motor position registers. A delay timer is built in and paces the steps. Each command is accepted with a valid/ready handshake and finishes with a done pulse. The block sits between the instruction controller and the motor phase decoders, and it replaces the per-instruction delay sequencing inside the controller.

## Interface
Parameters:
- `NUM_CH`, 2: number of motor channels (≥1); `CH_W = max(1, $clog2(NUM_CH))`.
- `POS_W`, 8: position width per channel, in half-step units.
- `CNT_W`, 8: signed step-count width.
- `DLY_W`, 20: step-delay width, in clk cycles.

Ports:
- `clk`, in, 1: clock.
- `reset_n`, in, 1: synchronous, active-low reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: high exactly when in IDLE.
- `cmd_op`, in, 2: 0 = MOVR, 1 = MOVRHS, 2 = PAUSE, 3 = NOP.
- `cmd_ch`, in, `CH_W`: target channel.
- `cmd_count`, in, `CNT_W`: signed step count; the sign gives direction.
- `cmd_delay`, in, `DLY_W`: cycles between steps; 0 is treated as 1.
- `abort`, in, 1: terminate the current command.
- `pos_q`, out, `NUM_CH*POS_W`: channel positions; channel i is at `[i*POS_W +: POS_W]`.
- `step_pulse`, out, `NUM_CH`: one-cycle pulse per step, per channel.
- `dir`, out, `NUM_CH`: last step direction per channel (1 = negative).
- `busy`, out, 1: equals `!cmd_ready`.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: pulses with `done` for an invalid channel.
- `aborted`, out, 1: pulses with `done` when terminated by `abort`.

## Operation
- States: IDLE, LOAD, STEP, DELAY, PDELAY.
- **IDLE:** the command is accepted when `cmd_valid && cmd_ready`. The op, channel, count and `D = max(cmd_delay,1)` are latched; next state is LOAD.
- **LOAD:**
  - If `cmd_ch >= NUM_CH` and op is not PAUSE/NOP: go to IDLE and pulse `done` and `err`.
  - PAUSE: load the timer with D, go to PDELAY.
  - NOP: go to IDLE and pulse `done`.
  - Otherwise: `temp <= count`, go to STEP.
- **STEP:**
  - If `temp == 0`: go to IDLE and pulse `done`.
  - Otherwise, on the selected channel: `pos += inc` when `temp > 0`, `pos -= inc` when `temp < 0`.
    - `inc` is 2 for MOVR and 1 for MOVRHS.
    - `temp` moves one toward zero.
    - `step_pulse[ch]` fires and `dir[ch]` updates.
  - Then load the timer with D and go to DELAY.
- **DELAY:** lasts exactly D cycles, then returns to STEP.
- **PDELAY:** lasts exactly D cycles, then goes to IDLE and pulses `done`.
- **Arithmetic:** position arithmetic is modulo `2^POS_W`, so it wraps silently. `temp` is `CNT_W` signed; a count of `-2^(CNT_W-1)` is legal.
- **Abort:** when `abort` is high in LOAD, STEP, DELAY or PDELAY, the next state is IDLE and `done` and `aborted` pulse.
  - `abort` takes priority over a step in the same STEP cycle: no position change, no `step_pulse`.
  - `abort` in IDLE is ignored.
- Channels not addressed by the current command never change.
- **Reset values:** state IDLE, all positions 0, `dir` 0, `step_pulse`/`done`/`err`/`aborted` 0, `cmd_ready` 1, `busy` 0. A reset mid-command discards the command and produces no `done`.

## Timing
- All outputs are registered.
- T is the accept cycle.
- A move with N≠0 steps and delay D:
  - `step_pulse` and the new `pos_q` are visible at T+3+k(D+1), for k = 0..N−1.
  - `done` arrives at T+3+N(D+1).
- N = 0: `done` at T+3.
- PAUSE: `done` at T+2+D.
- NOP and invalid channel: `done` at T+2.
- `done` coincides with the first IDLE cycle. A new command can be accepted in that same cycle.
- Abort asserted in cycle A produces `done` at A+1.

## Structure
- Shared package `step_seq_pkg`: opcode localparams (`OP_MOVR`, `OP_MOVRHS`, `OP_PAUSE`, `OP_NOP`), state encoding, and the `INC_FULL = 2` / `INC_HALF = 1` constants.
- One sub-module, `step_delay_timer`:
  - `DLY_W` down-counter with `load`, `load_val` and `enable` inputs.
  - Its `expired` output rises after exactly `load_val` enabled cycles.
  - Used by both DELAY and PDELAY.

## Test plan
- Reset with `cmd_valid` low. Required: `cmd_ready` = 1, `pos_q` all 0, no pulses. Then assert reset mid-MOVR. Required: IDLE the next cycle, positions return to 0, no `done`.
- MOVR, ch0, count 3, D 4, accepted at T:
  - `pos0` reads 2, 4, 6 at T+3, T+8, T+13.
  - `step_pulse[0]` fires at exactly those cycles.
  - `done` at T+18.
  - `pos1` stays 0 throughout.
- MOVRHS, ch1, count −2, `cmd_delay` 0, POS_W 8: `pos1` reads 255 then 254 (wrap-around), `dir[1]` = 1, `done` at T+7.
- PAUSE, D 10: `done` at T+12, no `step_pulse`. Then count 0 on MOVR: `done` at T+3, positions unchanged.
- MOVR, count 5, D 8, with `abort` asserted in the second DELAY cycle: `pos` stops at +4, `done` and `aborted` fire the next cycle. A new command accepted in the `done` cycle executes normally.
- With NUM_CH 3 and `cmd_ch` 3: `done` and `err` at T+2, no position change. The back-to-back command is accepted in the same cycle as `done`.
